// File: rtl/ordener_frame_packer.sv
// ordener_frame_packer: packs a serial valid/ready byte stream into 8-slot frames for the sorter,
// padding short frames (in_last or idle timeout) with PAD_VALUE and pulsing valid for one cycle.
module ordener_frame_packer #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] PAD_VALUE = {WIDTH{1'b1}},
    parameter int               TIMEOUT   = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             valid,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] a2,
    output logic [WIDTH-1:0] a3,
    output logic [WIDTH-1:0] a4,
    output logic [WIDTH-1:0] a5,
    output logic [WIDTH-1:0] a6,
    output logic [WIDTH-1:0] a7,
    output logic [WIDTH-1:0] a8,
    output logic [3:0]       out_fill,
    output logic [15:0]      short_cnt
);
    localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    typedef enum logic [1:0] {IDLE, FILL, EMIT} state_t;
    state_t           state, state_nx;
    logic [3:0]       count, fill_nx;
    logic [TW-1:0]    idle;
    logic [WIDTH-1:0] cap  [8];
    logic [WIDTH-1:0] slot [8];
    logic             accept, tmo, close;
    assign in_ready = state != EMIT;
    assign valid    = state == EMIT;
    assign accept   = in_valid & in_ready;
    assign fill_nx  = count + 4'(accept);
    assign tmo      = TIMEOUT > 0 && state == FILL && !accept && idle == TW'(TIMEOUT - 1);
    assign close    = (accept & (in_last | count == 4'd7)) | tmo;
    assign {a, a2, a3, a4, a5, a6, a7, a8} =
        {slot[0], slot[1], slot[2], slot[3], slot[4], slot[5], slot[6], slot[7]};
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        state_nx = state == EMIT ? IDLE : close ? EMIT : accept ? FILL : state;
    end
    // The frame-closing element is merged straight from in_data so it lands in the same edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count     <= '0;
            idle      <= '0;
            out_fill  <= '0;
            short_cnt <= '0;
            for (int k = 0; k < 8; k++) begin
                cap[k]  <= '0;
                slot[k] <= '0;
            end
        end else begin
            count <= close ? 4'd0 : fill_nx;
            idle  <= (accept || close || state != FILL) ? '0 : idle + 1'b1;
            if (accept) cap[count[2:0]] <= in_data;
            if (close) begin
                out_fill <= fill_nx;
                for (int k = 0; k < 8; k++)
                    slot[k] <= 4'(k) >= fill_nx ? PAD_VALUE :
                               (accept && 4'(k) == count) ? in_data : cap[k];
                if (fill_nx != 4'd8 && short_cnt != 16'hFFFF) short_cnt <= short_cnt + 16'd1;
            end
        end
    end
endmodule
